// File: rtl/load_sched_pkg.sv
// Shared state encodings and limits for the HBM load-group barrier scheduler.
// Latency: n/a (declarations only). Backpressure: n/a.
package load_sched_pkg;

    localparam int MAX_NUM_GROUP = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LAUNCH  = ST_LAUNCH,
        S_WAIT    = ST_WAIT,
        S_RELEASE = ST_RELEASE,
        S_ERROR   = ST_ERROR
    } sched_state_t;

    // Groups stay enabled from launch until the epoch stream ends.
    function automatic logic drives_launch(input logic [2:0] st);
        return (st == ST_LAUNCH) || (st == ST_WAIT) || (st == ST_RELEASE);
    endfunction

endpackage

// File: rtl/load_sched_ctrl_group_barrier.sv
// Per-group arrival bitmask for one barrier epoch; repeated pulses are idempotent.
// Latency: arrived registers one cycle after start_load. Backpressure: none, pulses are never stalled.
module group_barrier
    import load_sched_pkg::*;
#(
    parameter int NUM_GROUP = 4
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 seed,
    input  logic                 upd,
    input  logic [NUM_GROUP-1:0] start_load,
    input  logic [NUM_GROUP-1:0] en_mask,
    output logic [NUM_GROUP-1:0] arrived,
    output logic [NUM_GROUP-1:0] arrived_nxt,
    output logic                 all_arrived
);

    if (NUM_GROUP < 1 || NUM_GROUP > MAX_NUM_GROUP) begin : g_bad_num_group
        $error("group_barrier: NUM_GROUP out of range");
    end

    logic [NUM_GROUP-1:0] arrived_q;
    logic [NUM_GROUP-1:0] arrived_d;

    assign arrived_nxt = arrived_q | (start_load & en_mask);
    assign all_arrived = (arrived_nxt == en_mask);
    assign arrived     = arrived_q;

    // Seeding keeps pulses seen during the release cycle for the next epoch.
    always_comb begin
        arrived_d = arrived_q;
        if (clr) begin
            arrived_d = '0;
        end else if (seed) begin
            arrived_d = start_load & en_mask;
        end else if (upd) begin
            arrived_d = arrived_nxt;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            arrived_q <= '0;
        end else begin
            arrived_q <= arrived_d;
        end
    end

endmodule

// File: rtl/load_sched_ctrl.sv
// Barrier scheduler: launches enabled load groups, releases all once every group arrived; timeout under LOAD_SCHED_TIMEOUT_EN.
// Latency: all outputs registered; release pulse one cycle after the final arrival. Backpressure: none, waits on arrivals only.
module load_sched_ctrl
    import load_sched_pkg::*;
#(
    parameter int NUM_GROUP = 4,
    parameter int TIMEOUT_W = 16,
    parameter int EPOCH_W   = 32
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [NUM_GROUP-1:0] group_en,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [NUM_GROUP-1:0] start_load,
    output logic [NUM_GROUP-1:0] launch,
    output logic                 start_load_all,
    output logic                 busy,
    output logic [NUM_GROUP-1:0] arrived,
    output logic [NUM_GROUP-1:0] missing,
    output logic                 timeout_err,
    output logic [EPOCH_W-1:0]   epoch_cnt
);

    logic [2:0]           state_q, state_d;
    logic [NUM_GROUP-1:0] en_mask_q, en_mask_d;
    logic [NUM_GROUP-1:0] launch_q, launch_d;
    logic                 start_load_all_q, start_load_all_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;

    logic                 arr_clr, arr_seed, arr_upd;
    logic [NUM_GROUP-1:0] arrived_nxt;
    logic                 all_arrived;
    logic                 timeout_hit;

    group_barrier #(
        .NUM_GROUP (NUM_GROUP)
    ) u_group_barrier (
        .sclk        (sclk),
        .rst         (rst),
        .clr         (arr_clr),
        .seed        (arr_seed),
        .upd         (arr_upd),
        .start_load  (start_load),
        .en_mask     (en_mask_q),
        .arrived     (arrived),
        .arrived_nxt (arrived_nxt),
        .all_arrived (all_arrived)
    );

    // Abort beats completion, completion beats timeout.
    always_comb begin
        state_d   = state_q;
        en_mask_d = en_mask_q;
        arr_clr   = 1'b0;
        arr_seed  = 1'b0;
        arr_upd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arr_clr = 1'b1;
                if (run && (group_en != '0)) begin
                    state_d   = ST_LAUNCH;
                    en_mask_d = group_en;
                end
            end
            ST_LAUNCH: begin
                arr_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!run) begin
                    arr_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    arr_upd = 1'b1;
                    if (all_arrived) begin
                        state_d = ST_RELEASE;
                    end else if (timeout_hit) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_RELEASE: begin
                if (run) begin
                    arr_seed = 1'b1;
                    state_d  = ST_WAIT;
                end else begin
                    arr_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (!run) begin
                    arr_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                arr_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        launch_d         = drives_launch(state_d) ? en_mask_d : '0;
        start_load_all_d = (state_d == ST_RELEASE);
        epoch_d          = start_load_all_d ? epoch_q + EPOCH_W'(1) : epoch_q;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            en_mask_q        <= '0;
            launch_q         <= '0;
            start_load_all_q <= 1'b0;
            epoch_q          <= '0;
        end else begin
            state_q          <= state_d;
            en_mask_q        <= en_mask_d;
            launch_q         <= launch_d;
            start_load_all_q <= start_load_all_d;
            epoch_q          <= epoch_d;
        end
    end

`ifdef LOAD_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] budget_q, budget_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [NUM_GROUP-1:0] missing_q, missing_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 timer_on;

    // Loaded with budget-1 so expiry lands on exactly the budget-th WAIT cycle.
    assign timer_on    = (budget_q != '0);
    assign timeout_hit = timer_on && (timer_q == '0);

    always_comb begin
        budget_d      = budget_q;
        timer_d       = timer_q;
        missing_d     = missing_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (run && (group_en != '0)) begin
                    budget_d      = timeout_cycles;
                    missing_d     = '0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_LAUNCH, ST_RELEASE: begin
                timer_d = budget_q - TIMEOUT_W'(1);
            end
            ST_WAIT: begin
                if (run && !all_arrived) begin
                    if (timeout_hit) begin
                        missing_d     = en_mask_q & ~arrived_nxt;
                        timeout_err_d = 1'b1;
                    end else if (timer_on) begin
                        timer_d = timer_q - TIMEOUT_W'(1);
                    end
                end
            end
            default: begin
                budget_d = budget_q;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            budget_q      <= '0;
            timer_q       <= '0;
            missing_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            budget_q      <= budget_d;
            timer_q       <= timer_d;
            missing_q     <= missing_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign missing     = missing_q;
    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^timeout_cycles;
    assign timeout_hit           = 1'b0;
    assign missing               = '0;
    assign timeout_err           = 1'b0;
`endif

    assign launch         = launch_q;
    assign start_load_all = start_load_all_q;
    assign busy           = (state_q != ST_IDLE);
    assign epoch_cnt      = epoch_q;

endmodule

// File: tb/tb_load_sched_ctrl.sv
// Bench for load_sched_ctrl: directed barrier scenarios then random traffic against a cycle reference model.
// Follows LOAD_SCHED_TIMEOUT_EN so expectations match whichever build is compiled.
module tb_load_sched_ctrl;

    localparam int NG = 4;
    localparam int TW = 16;
    localparam int EW = 32;
`ifdef LOAD_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          sclk = 1'b0;
    logic          rst;
    logic          run;
    logic [NG-1:0] group_en;
    logic [TW-1:0] timeout_cycles;
    logic [NG-1:0] start_load;
    logic [NG-1:0] launch;
    logic          start_load_all;
    logic          busy;
    logic [NG-1:0] arrived;
    logic [NG-1:0] missing;
    logic          timeout_err;
    logic [EW-1:0] epoch_cnt;

    load_sched_ctrl #(
        .NUM_GROUP (NG),
        .TIMEOUT_W (TW),
        .EPOCH_W   (EW)
    ) dut (
        .sclk           (sclk),
        .rst            (rst),
        .run            (run),
        .group_en       (group_en),
        .timeout_cycles (timeout_cycles),
        .start_load     (start_load),
        .launch         (launch),
        .start_load_all (start_load_all),
        .busy           (busy),
        .arrived        (arrived),
        .missing        (missing),
        .timeout_err    (timeout_err),
        .epoch_cnt      (epoch_cnt)
    );

    always #5 sclk = ~sclk;

    int n_chk = 0;
    int n_err = 0;
    int rel_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase of the barrier epoch, arrival set, and a count of
    // WAIT cycles spent in the current epoch compared against the budget.
    localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WAIT = 2, PH_REL = 3, PH_ERR = 4;
    int          ph = PH_IDLE;
    bit [NG-1:0] m_mask, m_arr, m_launch, m_miss;
    bit          m_rel, m_terr;
    int          m_budget, m_waited;
    bit [EW-1:0] m_epoch;

    task model_step();
        bit [NG-1:0] seen;
        m_rel = 1'b0;
        if (rst) begin
            ph = PH_IDLE; m_mask = '0; m_arr = '0; m_launch = '0; m_miss = '0;
            m_terr = 1'b0; m_budget = 0; m_waited = 0; m_epoch = '0;
        end else begin
            case (ph)
                PH_IDLE: if (run && group_en != 0) begin
                    ph = PH_LAUNCH; m_mask = group_en; m_budget = int'(timeout_cycles);
                    m_miss = '0; m_terr = 1'b0; m_launch = group_en;
                end
                PH_LAUNCH: begin
                    ph = PH_WAIT; m_arr = '0; m_waited = 0;
                end
                PH_WAIT: begin
                    seen = m_arr | (start_load & m_mask);
                    if (!run) begin
                        ph = PH_IDLE; m_arr = '0; m_launch = '0;
                    end else if (seen == m_mask) begin
                        ph = PH_REL; m_arr = seen; m_rel = 1'b1; m_epoch = m_epoch + 1;
                    end else if (TMO_EN && m_budget != 0 && m_waited + 1 == m_budget) begin
                        ph = PH_ERR; m_arr = seen; m_miss = m_mask & ~seen;
                        m_terr = 1'b1; m_launch = '0;
                    end else begin
                        m_arr = seen; m_waited++;
                    end
                end
                PH_REL: begin
                    m_waited = 0;
                    if (run) begin
                        ph = PH_WAIT; m_arr = start_load & m_mask;
                    end else begin
                        ph = PH_IDLE; m_arr = '0; m_launch = '0;
                    end
                end
                default: if (!run) begin
                    ph = PH_IDLE; m_arr = '0;
                end
            endcase
        end
    endtask

    task step();
        model_step();
        @(posedge sclk);
        @(negedge sclk);
        if (start_load_all === 1'b1) rel_seen++;
        chk("m_launch", launch, m_launch);
        chk("m_release", start_load_all, m_rel);
        chk("m_busy", busy, ph != PH_IDLE);
        chk("m_arrived", arrived, m_arr);
        chk("m_missing", missing, m_miss);
        chk("m_timeout_err", timeout_err, m_terr);
        chk("m_epoch", epoch_cnt, m_epoch);
    endtask

    task go_idle();
        run = 1'b0;
        start_load = '0;
        step();
        step();
    endtask

    logic [NG-1:0] fb_seq [4] = '{4'b0001, 4'b0001, 4'b0100, 4'b0010};
    int r0;

    initial begin
        rst = 1'b1; run = 1'b0; group_en = '0; timeout_cycles = '0; start_load = '0;
        step();
        step();
        chk("rst_epoch", epoch_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_launch", launch, 0);

        // Full barrier with a duplicate pulse from group 0.
        rst = 1'b0; group_en = 4'hF; run = 1'b1;
        step();
        chk("fb_launch", launch, 4'hF);
        step();
        r0 = rel_seen;
        foreach (fb_seq[i]) begin
            start_load = fb_seq[i];
            step();
            chk("fb_early", start_load_all, 0);
        end
        start_load = 4'b1000;
        step();
        chk("fb_release", start_load_all, 1);
        chk("fb_epoch", epoch_cnt, 1);
        start_load = '0;
        step();
        chk("fb_one_pulse", rel_seen - r0, 1);
        go_idle();

        // Masking, then carry-over of a pulse seen in the release cycle.
        group_en = 4'b0101; run = 1'b1;
        step();
        step();
        chk("mask_launch", launch, 4'b0101);
        start_load = 4'b1010;
        step();
        chk("mask_ignored", start_load_all, 0);
        chk("mask_arr", arrived, 0);
        start_load = 4'b0101;
        step();
        chk("mask_release", start_load_all, 1);
        chk("mask_epoch", epoch_cnt, 2);
        start_load = 4'b0100;
        step();
        chk("carry_arr", arrived, 4'b0100);
        chk("carry_busy", busy, 1);
        go_idle();

        // Abort by run=0 while the last group pulses.
        group_en = 4'hF; run = 1'b1;
        step();
        step();
        start_load = 4'b0111;
        step();
        chk("abort_arr3", arrived, 4'b0111);
        run = 1'b0; start_load = 4'b1000;
        step();
        chk("abort_rel", start_load_all, 0);
        chk("abort_arr", arrived, 0);
        chk("abort_launch", launch, 0);

        // Abort by reset.
        start_load = '0; run = 1'b1;
        step();
        step();
        start_load = 4'b0111;
        step();
        rst = 1'b1; start_load = 4'b1000;
        step();
        chk("rstab_rel", start_load_all, 0);
        chk("rstab_arr", arrived, 0);
        chk("rstab_launch", launch, 0);
        chk("rstab_epoch", epoch_cnt, 0);

        // Timeout: only group 0 ever arrives within a 10-cycle budget.
        rst = 1'b0; timeout_cycles = 16'd10; start_load = '0;
        step();
        step();
        start_load = 4'b0001;
        step();
        start_load = '0;
        for (int i = 0; i < 8; i++) step();
        chk("to_early", timeout_err, 0);
        step();
        chk("to_err", timeout_err, TMO_EN);
        chk("to_missing", missing, TMO_EN ? 4'hE : 4'h0);
        chk("to_launch", launch, TMO_EN ? 4'h0 : 4'hF);
        run = 1'b0;
        step();
        chk("to_idle", busy, 0);
        chk("to_sticky", timeout_err, TMO_EN);

        // Tie: final arrival on the expiry cycle wins.
        run = 1'b1;
        step();
        step();
        start_load = 4'b0001;
        step();
        start_load = '0;
        for (int i = 0; i < 8; i++) step();
        start_load = 4'b1110;
        step();
        chk("tie_release", start_load_all, 1);
        chk("tie_err", timeout_err, 0);
        go_idle();

        // Random traffic.
        run = 1'b1;
        timeout_cycles = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 15) == 0) group_en = NG'($urandom);
            if ($urandom_range(0, 15) == 0) timeout_cycles = TW'($urandom_range(0, 12));
            start_load = NG'($urandom & $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
